// File: rtl/dma_channel_arbiter.sv
// Arbitrates NUM_CH DMA requesters onto one transfer engine and runs the CPU HOLD/ACK handshake.
// Optional macro DMA_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module dma_channel_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ADDR_W  = 65,
    parameter int unsigned LEN_W   = 64,
    parameter int unsigned ACK_TMO = 255
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH*ADDR_W-1:0]   req_ram_addr,
    input  logic [NUM_CH*ADDR_W-1:0]   req_disk_addr,
    input  logic [NUM_CH*LEN_W-1:0]    req_amount,
    input  logic [NUM_CH-1:0]          req_read,
    input  logic [NUM_CH-1:0]          req_write,
    output logic [NUM_CH-1:0]          grant,
    output logic [NUM_CH-1:0]          done,
    output logic [NUM_CH-1:0]          err,
    output logic                       HOLD,
    input  logic                       ACK,
    output logic [ADDR_W-1:0]          dma_ram_addr,
    output logic [ADDR_W-1:0]          dma_disk_addr,
    output logic [LEN_W-1:0]           dma_amount,
    output logic                       dma_read,
    output logic                       dma_write,
    output logic                       dma_start,
    input  logic                       dma_finish,
    output logic                       busy
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(ACK_TMO + 1);

    typedef enum logic [2:0] {IDLE, HOLD_REQ, START, RUN, RELEASE} state_t;

    state_t            state;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic              win_vld;
    logic [CNT_W-1:0]  cnt;
    logic              tmo_c;
    logic [ADDR_W-1:0] sel_ram;
    logic [ADDR_W-1:0] sel_disk;
    logic [LEN_W-1:0]  sel_amount;
    logic              sel_read;
    logic              sel_write;

    function automatic logic [NUM_CH-1:0] onehot(input logic [PTR_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

`ifdef DMA_ARB_FIXED_PRIO_EN
    localparam logic [PTR_W-1:0] rr_ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    logic             fin_c;
    logic [PTR_W-1:0] fin_idx_c;

    // A channel is finished (done or err) this edge: the pointer moves past it.
    always_comb begin
        fin_c     = 1'b0;
        fin_idx_c = owner;
        case (state)
            IDLE: begin
                if (win_vld && ((sel_read == sel_write) || (sel_amount == '0))) begin
                    fin_c     = 1'b1;
                    fin_idx_c = win_idx;
                end
            end
            HOLD_REQ: fin_c = !ACK && tmo_c;
            RUN:      fin_c = dma_finish;
            default:  fin_c = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (fin_c) begin
            rr_ptr <= (fin_idx_c == PTR_W'(NUM_CH - 1)) ? '0 : fin_idx_c + PTR_W'(1);
        end
    end
`endif

    // Scan downward so the first set request at or after rr_ptr is the last to overwrite.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            scan_idx = PTR_W'((int'(rr_ptr) + i) % int'(NUM_CH));
            if (req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        sel_ram    = '0;
        sel_disk   = '0;
        sel_amount = '0;
        sel_read   = 1'b0;
        sel_write  = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_ram    = req_ram_addr[i*ADDR_W +: ADDR_W];
                sel_disk   = req_disk_addr[i*ADDR_W +: ADDR_W];
                sel_amount = req_amount[i*LEN_W +: LEN_W];
                sel_read   = req_read[i];
                sel_write  = req_write[i];
            end
        end
    end

    assign tmo_c = (cnt == CNT_W'(ACK_TMO - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= '0;
            done          <= '0;
            err           <= '0;
            HOLD          <= 1'b0;
            dma_ram_addr  <= '0;
            dma_disk_addr <= '0;
            dma_amount    <= '0;
            dma_read      <= 1'b0;
            dma_write     <= 1'b0;
            dma_start     <= 1'b0;
            busy          <= 1'b0;
            cnt           <= '0;
            owner         <= '0;
        end else begin
            done      <= '0;
            err       <= '0;
            dma_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        dma_ram_addr  <= sel_ram;
                        dma_disk_addr <= sel_disk;
                        dma_amount    <= sel_amount;
                        dma_read      <= sel_read;
                        dma_write     <= sel_write;
                        owner         <= win_idx;
                        // Malformed direction is an error; an empty transfer completes trivially.
                        if (sel_read == sel_write) begin
                            err <= onehot(win_idx);
                        end else if (sel_amount == '0) begin
                            done <= onehot(win_idx);
                        end else begin
                            grant <= onehot(win_idx);
                            HOLD  <= 1'b1;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            state <= HOLD_REQ;
                        end
                    end
                end
                HOLD_REQ: begin
                    if (ACK) begin
                        cnt   <= '0;
                        state <= START;
                    end else if (tmo_c) begin
                        HOLD  <= 1'b0;
                        err   <= onehot(owner);
                        grant <= '0;
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                START: begin
                    dma_start <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (dma_finish) begin
                        done  <= onehot(owner);
                        HOLD  <= 1'b0;
                        grant <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ACK) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: randomized requesters, CPU and engine agents checked against a transaction-level model.
// Honours DMA_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_dma_channel_arbiter;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned ADDR_W  = 65;
    localparam int unsigned LEN_W   = 64;
    localparam int unsigned ACK_TMO = 16;

    logic                     clock;
    logic                     reset_n;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*ADDR_W-1:0] req_ram_addr;
    logic [NUM_CH*ADDR_W-1:0] req_disk_addr;
    logic [NUM_CH*LEN_W-1:0]  req_amount;
    logic [NUM_CH-1:0]        req_read;
    logic [NUM_CH-1:0]        req_write;
    logic [NUM_CH-1:0]        grant;
    logic [NUM_CH-1:0]        done;
    logic [NUM_CH-1:0]        err;
    logic                     HOLD;
    logic                     ACK;
    logic [ADDR_W-1:0]        dma_ram_addr;
    logic [ADDR_W-1:0]        dma_disk_addr;
    logic [LEN_W-1:0]         dma_amount;
    logic                     dma_read;
    logic                     dma_write;
    logic                     dma_start;
    logic                     dma_finish;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    int          ack_mode;
    bit          eng_rand;
    int          eng_lat;
    int          eng_cnt;
    bit          rand_req_en;
    logic [NUM_CH-1:0] hold_mask;

    dma_channel_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .ACK_TMO(ACK_TMO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .req_ram_addr (req_ram_addr),
        .req_disk_addr(req_disk_addr),
        .req_amount   (req_amount),
        .req_read     (req_read),
        .req_write    (req_write),
        .grant        (grant),
        .done         (done),
        .err          (err),
        .HOLD         (HOLD),
        .ACK          (ACK),
        .dma_ram_addr (dma_ram_addr),
        .dma_disk_addr(dma_disk_addr),
        .dma_amount   (dma_amount),
        .dma_read     (dma_read),
        .dma_write    (dma_write),
        .dma_start    (dma_start),
        .dma_finish   (dma_finish),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_desc(input int ch, input logic [ADDR_W-1:0] ram, input logic [ADDR_W-1:0] disk,
                            input logic [LEN_W-1:0] amt, input logic rd, input logic wr);
        req_ram_addr[ch*ADDR_W +: ADDR_W] = ram;
        req_disk_addr[ch*ADDR_W +: ADDR_W] = disk;
        req_amount[ch*LEN_W +: LEN_W]      = amt;
        req_read[ch]                       = rd;
        req_write[ch]                      = wr;
    endtask

    task automatic rand_desc(input int ch);
        int unsigned r;
        logic rd, wr;
        logic [LEN_W-1:0] amt;
        r  = $urandom_range(0, 9);
        rd = (r == 1) ? 1'b1 : (r == 0) ? 1'b0 : r[0];
        wr = (r == 1) ? 1'b1 : (r == 0) ? 1'b0 : ~r[0];
        amt = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
        set_desc(ch, {1'($urandom_range(0, 1)), $urandom, $urandom},
                 {1'($urandom_range(0, 1)), $urandom, $urandom}, amt, rd, wr);
    endtask

    // Requesters: hold req until done/err, optionally drop after grant, optionally re-raise.
    always @(negedge clock) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (req[i] && (done[i] || err[i])) begin
                req[i] = 1'b0;
            end else if (rand_req_en && req[i] && grant[i] && $urandom_range(0, 7) == 0) begin
                req[i] = 1'b0;
            end else if (!req[i] && !grant[i] && hold_mask[i] && !done[i] && !err[i]) begin
                req[i] = 1'b1;
            end else if (!req[i] && !grant[i] && rand_req_en && $urandom_range(0, 5) == 0) begin
                rand_desc(i);
                req[i] = 1'b1;
            end
            if (rand_req_en && grant[i]) rand_desc(i);
        end
    end

    // CPU side: 0 = ACK mirrors HOLD, 1 = never acknowledge, else random delays and drops.
    always @(negedge clock) begin
        case (ack_mode)
            0: ACK = HOLD;
            1: ACK = 1'b0;
            default: begin
                if (HOLD && !ACK)                                ACK = ($urandom_range(0, 3) == 0);
                else if (!HOLD && ACK)                           ACK = ($urandom_range(0, 1) == 0);
                else if (HOLD && ACK && $urandom_range(0, 7) == 0) ACK = 1'b0;
            end
        endcase
    end

    // Engine: finish a fixed or random number of cycles after the start pulse.
    always @(negedge clock) begin
        dma_finish = 1'b0;
        if (!reset_n) begin
            eng_cnt = 0;
        end else if (dma_start) begin
            eng_cnt = eng_rand ? int'($urandom_range(1, 8)) : eng_lat;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) dma_finish = 1'b1;
        end
    end

    // Reference model, advanced once per edge from the inputs the DUT samples.
    int                m_phase;   // 0 idle, 1 awaiting ack, 2 start, 3 transfer, 4 release
    int                m_rr;
    int                m_own;
    int                m_hold_cycles;
    logic [NUM_CH-1:0] e_grant, e_done, e_err;
    logic              e_hold, e_start, e_busy;
    logic [ADDR_W-1:0] e_ram, e_disk;
    logic [LEN_W-1:0]  e_amt;
    logic              e_rd, e_wr;

    function automatic int next_ptr(input int w);
`ifdef DMA_ARB_FIXED_PRIO_EN
        return 0 * w;
`else
        return (w + 1) % int'(NUM_CH);
`endif
    endfunction

    always @(posedge clock) begin
        int w;
        if (!reset_n) begin
            m_phase = 0; m_rr = 0; m_own = 0; m_hold_cycles = 0;
            e_grant = '0; e_done = '0; e_err = '0;
            e_hold = 1'b0; e_start = 1'b0; e_busy = 1'b0;
            e_ram = '0; e_disk = '0; e_amt = '0; e_rd = 1'b0; e_wr = 1'b0;
        end else begin
            e_done = '0; e_err = '0; e_start = 1'b0;
            case (m_phase)
                0: begin
                    w = -1;
                    for (int k = 0; k < int'(NUM_CH); k++)
                        if (w < 0 && req[(m_rr + k) % int'(NUM_CH)]) w = (m_rr + k) % int'(NUM_CH);
                    if (w >= 0) begin
                        if (req_read[w] == req_write[w]) begin
                            e_err[w] = 1'b1;
                            m_rr = next_ptr(w);
                        end else if (req_amount[w*LEN_W +: LEN_W] == '0) begin
                            e_done[w] = 1'b1;
                            m_rr = next_ptr(w);
                        end else begin
                            m_own = w;
                            e_grant = '0; e_grant[w] = 1'b1;
                            e_hold = 1'b1;
                            e_ram  = req_ram_addr[w*ADDR_W +: ADDR_W];
                            e_disk = req_disk_addr[w*ADDR_W +: ADDR_W];
                            e_amt  = req_amount[w*LEN_W +: LEN_W];
                            e_rd   = req_read[w];
                            e_wr   = req_write[w];
                            m_hold_cycles = 0;
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    m_hold_cycles++;
                    if (ACK) begin
                        m_phase = 2;
                    end else if (m_hold_cycles == int'(ACK_TMO)) begin
                        e_hold = 1'b0; e_grant = '0; e_err[m_own] = 1'b1;
                        m_rr = next_ptr(m_own);
                        m_phase = 4;
                    end
                end
                2: begin
                    e_start = 1'b1;
                    m_phase = 3;
                end
                3: begin
                    if (dma_finish) begin
                        e_hold = 1'b0; e_grant = '0; e_done[m_own] = 1'b1;
                        m_rr = next_ptr(m_own);
                        m_phase = 4;
                    end
                end
                default: if (!ACK) m_phase = 0;
            endcase
            e_busy = (m_phase != 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clock) begin
        #1;
        chk("grant", grant, e_grant);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("hold", HOLD, e_hold);
        chk("dma_start", dma_start, e_start);
        chk("busy", busy, e_busy);
        if (e_grant != '0) begin
            chk("dma_ram_addr", dma_ram_addr, e_ram);
            chk("dma_disk_addr", dma_disk_addr, e_disk);
            chk("dma_amount", dma_amount, e_amt);
            chk("dma_read", dma_read, e_rd);
            chk("dma_write", dma_write, e_wr);
        end
    end

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(posedge clock); #1;
            if (!busy && req == '0 && grant == '0) ok = 1'b1;
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_grant(input string name, input int budget, output logic [NUM_CH-1:0] g);
        bit ok;
        ok = 1'b0;
        g  = '0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(posedge clock); #1;
            if (grant != '0) begin ok = 1'b1; g = grant; end
        end
        chk(name, ok, 1);
    endtask

    logic [NUM_CH-1:0] order_exp [4];
    logic [NUM_CH-1:0] g;
    logic [NUM_CH-1:0] tmo_first, tmo_next;
    int                hc;
    bit                seen;

    initial begin
`ifdef DMA_ARB_FIXED_PRIO_EN
        order_exp[0] = 4'b0001; order_exp[1] = 4'b0001; order_exp[2] = 4'b0001; order_exp[3] = 4'b0001;
        tmo_first = 4'b0001; tmo_next = 4'b1000;
`else
        order_exp[0] = 4'b0001; order_exp[1] = 4'b0010; order_exp[2] = 4'b1000; order_exp[3] = 4'b0001;
        tmo_first = 4'b1000; tmo_next = 4'b0001;
`endif
        reset_n = 1'b0; ACK = 1'b0; dma_finish = 1'b0;
        req_ram_addr = '0; req_disk_addr = '0; req_amount = '0; req_read = '0; req_write = '0;
        ack_mode = 0; eng_rand = 1'b0; eng_lat = 4; eng_cnt = 0; rand_req_en = 1'b0; hold_mask = '0;
        for (int i = 0; i < int'(NUM_CH); i++) set_desc(i, ADDR_W'(1000 + i), ADDR_W'(2000 + i), LEN_W'(4), 1'b1, 1'b0);
        req = '1;

        // Reset with every channel requesting.
        repeat (2) begin
            @(posedge clock); #1;
            chk("rst_grant", grant, 0);
            chk("rst_hold", HOLD, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ram", dma_ram_addr, 0);
        end
        @(negedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;
        chk("first_grant", grant, 4'b0001);
        wait_idle("drain_after_reset", 300);

        // Held requests on 0,1,3: arbitration order.
        @(negedge clock); #1;
        hold_mask = 4'b1011;
        req = 4'b1011;
        for (int n = 0; n < 4; n++) begin
            wait_grant("rr_grant_seen", 60, g);
            chk("rr_order", g, order_exp[n]);
            seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(posedge clock); #1;
                if (grant == '0) seen = 1'b1;
            end
            chk("rr_release_seen", seen, 1);
        end
        @(negedge clock); #1 hold_mask = '0;
        wait_idle("drain_rr", 300);

        // Single transfer on channel 2 with ACK tied to HOLD.
        eng_lat = 8;
        @(negedge clock); #1;
        set_desc(2, ADDR_W'(100), ADDR_W'(500), LEN_W'(8), 1'b1, 1'b0);
        req[2] = 1'b1;
        @(posedge clock); #1;
        chk("single_hold", HOLD, 1);
        chk("single_grant", grant, 4'b0100);
        @(posedge clock); #1;
        chk("single_start_early", dma_start, 0);
        @(posedge clock); #1;
        chk("single_start", dma_start, 1);
        chk("single_ram", dma_ram_addr, 100);
        chk("single_disk", dma_disk_addr, 500);
        chk("single_amount", dma_amount, 8);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clock); #1;
            if (done != '0) seen = 1'b1;
        end
        chk("single_done_seen", seen, 1);
        chk("single_done", done, 4'b0100);
        chk("single_hold_low", HOLD, 0);
        wait_idle("drain_single", 50);

        // Rejects: bad direction, then zero length.
        @(negedge clock); #1;
        set_desc(1, ADDR_W'(7), ADDR_W'(9), LEN_W'(5), 1'b1, 1'b1);
        req[1] = 1'b1;
        @(posedge clock); #1;
        chk("rej_dir_err", err, 4'b0010);
        chk("rej_dir_hold", HOLD, 0);
        @(negedge clock); #1;
        set_desc(1, ADDR_W'(7), ADDR_W'(9), LEN_W'(0), 1'b1, 1'b0);
        req[1] = 1'b1;
        @(posedge clock); #1;
        chk("rej_len_done", done, 4'b0010);
        chk("rej_len_err", err, 4'b0000);
        chk("rej_len_hold", HOLD, 0);
        wait_idle("drain_reject", 20);

        // ACK never arrives: grant aborts after ACK_TMO cycles of HOLD.
        @(negedge clock); #1;
        ack_mode = 1;
        set_desc(3, ADDR_W'(33), ADDR_W'(44), LEN_W'(2), 1'b0, 1'b1);
        set_desc(0, ADDR_W'(11), ADDR_W'(22), LEN_W'(3), 1'b1, 1'b0);
        req[3] = 1'b1; req[0] = 1'b1;
        hc = 0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clock); #1;
            if (HOLD) hc++;
            else if (hc > 0) seen = 1'b1;
        end
        chk("tmo_hold_cycles", hc, ACK_TMO);
        chk("tmo_err", err, tmo_first);
        @(negedge clock); #1 ack_mode = 0;
        wait_grant("tmo_next_seen", 30, g);
        chk("tmo_next_grant", g, tmo_next);
        wait_idle("drain_tmo", 100);

        // Reset two cycles after the start pulse: no completion reported.
        eng_lat = 20;
        @(negedge clock); #1;
        set_desc(1, ADDR_W'(5), ADDR_W'(6), LEN_W'(9), 1'b1, 1'b0);
        req[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clock); #1;
            if (dma_start) seen = 1'b1;
        end
        chk("mid_start_seen", seen, 1);
        @(negedge clock);
        @(negedge clock); #1 reset_n = 1'b0;
        @(posedge clock); #1;
        chk("mid_rst_hold", HOLD, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clock); #1 req[1] = 1'b0;
        @(negedge clock); #1 reset_n = 1'b1;
        wait_idle("drain_mid_rst", 20);

        // Randomized traffic with random CPU and engine timing.
        @(negedge clock); #1;
        ack_mode = 2; eng_rand = 1'b1; rand_req_en = 1'b1;
        repeat (4000) @(posedge clock);
        @(negedge clock); #1 rand_req_en = 1'b0;
        wait_idle("drain_random", 1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
